// File: rtl/sobel_patch_engine.sv
// 3x3 Sobel patch engine: fetches nine pixels over a req/gnt/rvalid read port,
// then computes Gx, Gy or |Gx|+|Gy| with a threshold-match flag.
module sobel_patch_engine #(
   parameter int PIXEL_W  = 8,
   parameter int ADDR_W   = 32,
   parameter int STRIDE_W = 16,
   localparam int RES_W   = PIXEL_W + 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic [ADDR_W-1:0]   cfg_base_i,
   input  logic [STRIDE_W-1:0] cfg_stride_i,
   input  logic [1:0]          cfg_mode_i,
   input  logic [RES_W-1:0]    cfg_thresh_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [RES_W-1:0]    result_o,
   output logic                match_o,
   output logic                sram_req_o,
   output logic [ADDR_W-1:0]   sram_addr_o,
   input  logic                sram_gnt_i,
   input  logic [PIXEL_W-1:0]  sram_rdata_i,
   input  logic                sram_rvalid_i
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CALC, S_DONE} state_t;

   state_t                     state_q, state_d;
   logic [3:0]                 idx_q, idx_d;
   logic [ADDR_W-1:0]          base_q, base_d;
   logic [STRIDE_W-1:0]        stride_q, stride_d;
   logic [1:0]                 mode_q, mode_d;
   logic [RES_W-1:0]           thresh_q, thresh_d;
   logic [PIXEL_W-1:0]         patch_q [9];
   logic [PIXEL_W-1:0]         patch_d [9];
   logic signed [RES_W-1:0]    result_q, result_d;
   logic                       match_q, match_d;

   logic signed [RES_W-1:0]    gx, gy, res_calc;
   logic [1:0]                 row, col;
   logic [ADDR_W-1:0]          row_off;

   function automatic logic signed [RES_W-1:0] zx(input logic [PIXEL_W-1:0] p);
      return $signed({{(RES_W-PIXEL_W){1'b0}}, p});
   endfunction

   // Magnitude never overflows: the largest |G| is 4*(2^PIXEL_W-1).
   function automatic logic [RES_W-1:0] mag(input logic signed [RES_W-1:0] v);
      return v[RES_W-1] ? $unsigned(-v) : $unsigned(v);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         base_q   <= '0;
         stride_q <= '0;
         mode_q   <= '0;
         thresh_q <= '0;
         result_q <= '0;
         match_q  <= 1'b0;
         for (int i = 0; i < 9; i++) patch_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         base_q   <= base_d;
         stride_q <= stride_d;
         mode_q   <= mode_d;
         thresh_q <= thresh_d;
         result_q <= result_d;
         match_q  <= match_d;
         for (int i = 0; i < 9; i++) patch_q[i] <= patch_d[i];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (start_i) state_d = S_REQ;
         S_REQ:          if (sram_gnt_i) state_d = S_WAIT;
         S_WAIT:         if (sram_rvalid_i) state_d = (idx_q == 4'd8) ? S_CALC : S_REQ;
         S_CALC:         state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase
   end

   always_comb begin
      gx = (zx(patch_q[2]) + (zx(patch_q[5]) <<< 1) + zx(patch_q[8]))
         - (zx(patch_q[0]) + (zx(patch_q[3]) <<< 1) + zx(patch_q[6]));
      gy = (zx(patch_q[6]) + (zx(patch_q[7]) <<< 1) + zx(patch_q[8]))
         - (zx(patch_q[0]) + (zx(patch_q[1]) <<< 1) + zx(patch_q[2]));
      case (mode_q)
         2'd0:    res_calc = gx;
         2'd1:    res_calc = gy;
         default: res_calc = $signed(mag(gx) + mag(gy));
      endcase
   end

   // Only an idle or finished engine samples cfg; rvalid is consumed solely in WAIT.
   always_comb begin
      idx_d    = idx_q;
      base_d   = base_q;
      stride_d = stride_q;
      mode_d   = mode_q;
      thresh_d = thresh_q;
      result_d = result_q;
      match_d  = match_q;
      for (int i = 0; i < 9; i++) patch_d[i] = patch_q[i];
      if ((state_q == S_IDLE || state_q == S_DONE) && start_i) begin
         idx_d    = '0;
         base_d   = cfg_base_i;
         stride_d = cfg_stride_i;
         mode_d   = cfg_mode_i;
         thresh_d = cfg_thresh_i;
      end
      if (state_q == S_WAIT && sram_rvalid_i) begin
         for (int i = 0; i < 9; i++)
            if (idx_q == 4'(i)) patch_d[i] = sram_rdata_i;
         if (idx_q != 4'd8) idx_d = idx_q + 4'd1;
      end
      if (state_q == S_CALC) begin
         result_d = res_calc;
         match_d  = mag(res_calc) > thresh_q;
      end
   end

   always_comb begin
      if (idx_q >= 4'd6) begin
         row = 2'd2;
         col = 2'(idx_q - 4'd6);
      end else if (idx_q >= 4'd3) begin
         row = 2'd1;
         col = 2'(idx_q - 4'd3);
      end else begin
         row = 2'd0;
         col = idx_q[1:0];
      end
      case (row)
         2'd1:    row_off = ADDR_W'(stride_q);
         2'd2:    row_off = ADDR_W'({stride_q, 1'b0});
         default: row_off = '0;
      endcase
      sram_addr_o = base_q + row_off + ADDR_W'(col);
      sram_req_o  = (state_q == S_REQ);
      busy_o      = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_CALC);
      done_o      = (state_q == S_DONE);
      result_o    = result_q;
      match_o     = match_q;
   end

endmodule
